// File: rtl/p_dispatch_pkg.sv
// Shared types for the dispatch (P) stage: rename bundle, issue-queue packet, target mapping.
// Zero latency (types only); no backpressure of its own.
package p_dispatch_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int ROB_W     = $clog2(ROB_DEPTH);
  localparam int CDB_PORTS = 2;

  typedef enum logic [2:0] {
    IT_ALU   = 3'd0,
    IT_MUL   = 3'd1,
    IT_BR    = 3'd2,
    IT_LOAD  = 3'd3,
    IT_STORE = 3'd4
  } inst_type_e;

  typedef enum logic {IQ_ALU = 1'b0, IQ_LSU = 1'b1} iq_target_e;

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} disp_state_e;

  typedef struct packed {
    logic             r_valid;
    inst_type_e       inst_type;
    logic [ROB_W-1:0] preg;
    logic             check;
    logic [31:0]      imm;
  } r_p_slot_t;

  typedef struct packed {
    logic [ROB_W-1:0] src_preg;
    logic [31:0]      arf_data;
    logic             data_valid;
  } r_p_src_t;

  typedef struct packed {
    r_p_slot_t [1:0] slot;
    r_p_src_t  [3:0] src;
  } r_p_pkg_t;

  typedef struct packed {
    inst_type_e       inst_type;
    logic [ROB_W-1:0] preg;
    logic             check;
    logic [31:0]      imm;
  } p_slot_pay_t;

  typedef struct packed {
    inst_type_e             inst_type;
    logic [ROB_W-1:0]       preg;
    logic                   check;
    logic [31:0]            imm;
    logic [1:0]             src_rdy;
    logic [1:0][ROB_W-1:0]  src_robid;
    logic [1:0][31:0]       src_data;
  } p_iq_pkg_t;

  function automatic iq_target_e inst_target(input inst_type_e t);
    return (t == IT_LOAD || t == IT_STORE) ? IQ_LSU : IQ_ALU;
  endfunction

endpackage

// File: rtl/p_operand_slot.sv
// One source operand: captures rdy/data at bundle accept, then snoops the CDB until ready.
// Output is registered state plus same-cycle CDB bypass; no backpressure.
module p_operand_slot
  import p_dispatch_pkg::*;
#(
  parameter int CDB_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_cap,
  input  r_p_src_t                         i_src,
  input  logic                             i_rob_rvalid,
  input  logic [31:0]                      i_rob_rdata,
  input  logic [CDB_PORTS-1:0]             i_cdb_valid,
  input  logic [CDB_PORTS-1:0][ROB_W-1:0]  i_cdb_robid,
  input  logic [CDB_PORTS-1:0][31:0]       i_cdb_data,
  output logic                             o_rdy,
  output logic [31:0]                      o_data,
  output logic [ROB_W-1:0]                 o_robid
);

  logic             r_rdy;
  logic [31:0]      r_data;
  logic [ROB_W-1:0] r_robid;

  logic        w_cap_hit;
  logic [31:0] w_cap_data;
  logic        w_snp_hit;
  logic [31:0] w_snp_data;

  // Walk ports high to low so the lowest-index hit is the one that sticks.
  always_comb begin
    w_cap_hit  = 1'b0;
    w_cap_data = '0;
    w_snp_hit  = 1'b0;
    w_snp_data = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (i_cdb_valid[p] && i_cdb_robid[p] == i_src.src_preg) begin
        w_cap_hit  = 1'b1;
        w_cap_data = i_cdb_data[p];
      end
      if (i_cdb_valid[p] && i_cdb_robid[p] == r_robid) begin
        w_snp_hit  = 1'b1;
        w_snp_data = i_cdb_data[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdy   <= 1'b0;
      r_data  <= '0;
      r_robid <= '0;
    end else if (i_cap) begin
      r_rdy   <= i_src.data_valid | i_rob_rvalid | w_cap_hit;
      r_robid <= i_src.src_preg;
      r_data  <= w_cap_hit ? w_cap_data : (i_rob_rvalid ? i_rob_rdata : i_src.arf_data);
    end else if (!r_rdy && w_snp_hit) begin
      r_rdy  <= 1'b1;
      r_data <= w_snp_data;
    end
  end

  assign o_rdy   = r_rdy | w_snp_hit;
  assign o_data  = (!r_rdy && w_snp_hit) ? w_snp_data : r_data;
  assign o_robid = r_robid;

endmodule

// File: rtl/p_dispatch.sv
// Two-wide dispatch: holds one renamed bundle and issues it in order to the ALU/LSU queues.
// Capture at edge N, earliest dispatch in N+1; rename is stalled until the held bundle fully drains.
module p_dispatch
  import p_dispatch_pkg::*;
#(
  parameter int ROB_DEPTH = 64,
  parameter int CDB_PORTS = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     r_p_valid_i,
  output logic                                     r_p_ready_o,
  input  r_p_pkg_t                                 r_p_data_i,
  output logic [3:0][$clog2(ROB_DEPTH)-1:0]        rob_raddr_o,
  input  logic [3:0]                               rob_rvalid_i,
  input  logic [3:0][31:0]                         rob_rdata_i,
  input  logic [CDB_PORTS-1:0]                     cdb_valid_i,
  input  logic [CDB_PORTS-1:0][$clog2(ROB_DEPTH)-1:0] cdb_robid_i,
  input  logic [CDB_PORTS-1:0][31:0]               cdb_data_i,
  output logic                                     alu_valid_o,
  input  logic                                     alu_ready_i,
  output p_iq_pkg_t                                alu_data_o,
  output logic                                     lsu_valid_o,
  input  logic                                     lsu_ready_i,
  output p_iq_pkg_t                                lsu_data_o,
  input  logic                                     c_flush_i
);

  disp_state_e r_state;
  disp_state_e w_state_nxt;
  logic [1:0]  r_pend;
  logic [1:0]  w_pend_nxt;
  iq_target_e  r_tgt [2];
  p_slot_pay_t r_pay [2];

  logic [3:0]             w_src_rdy;
  logic [3:0][31:0]       w_src_data;
  logic [3:0][ROB_W-1:0]  w_src_robid;
  p_iq_pkg_t              w_pkt [2];

  logic       w_live, w_rdy0, w_rdy1;
  logic       w_off0, w_off1, w_disp0, w_disp1, w_drain, w_cap;
  logic       w_alu0, w_alu1, w_lsu0, w_lsu1;
  logic [1:0] w_rv;

  for (genvar j = 0; j < 4; j++) begin : g_src
    assign rob_raddr_o[j] = r_p_data_i.src[j].src_preg;

    p_operand_slot #(.CDB_PORTS(CDB_PORTS)) u_opnd (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cap        (w_cap),
      .i_src        (r_p_data_i.src[j]),
      .i_rob_rvalid (rob_rvalid_i[j]),
      .i_rob_rdata  (rob_rdata_i[j]),
      .i_cdb_valid  (cdb_valid_i),
      .i_cdb_robid  (cdb_robid_i),
      .i_cdb_data   (cdb_data_i),
      .o_rdy        (w_src_rdy[j]),
      .o_data       (w_src_data[j]),
      .o_robid      (w_src_robid[j])
    );
  end

  assign w_rv   = {r_p_data_i.slot[1].r_valid, r_p_data_i.slot[0].r_valid};
  assign w_live = rst_n & ~c_flush_i;
  assign w_rdy0 = (r_tgt[0] == IQ_ALU) ? alu_ready_i : lsu_ready_i;
  assign w_rdy1 = (r_tgt[1] == IQ_ALU) ? alu_ready_i : lsu_ready_i;

  // Slot1 may only overtake a still-pending slot0 when slot0 leaves this cycle on the other queue.
  assign w_off0  = w_live & r_pend[0];
  assign w_disp0 = w_off0 & w_rdy0;
  assign w_off1  = w_live & r_pend[1] & (~r_pend[0] | (w_disp0 & (r_tgt[1] != r_tgt[0])));
  assign w_disp1 = w_off1 & w_rdy1;
  assign w_drain = (~r_pend[0] | w_disp0) & (~r_pend[1] | w_disp1);

  assign r_p_ready_o = w_live & ((r_state == ST_EMPTY) | w_drain);
  assign w_cap       = r_p_valid_i & r_p_ready_o;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_pkt[k]           = '0;
      w_pkt[k].inst_type = r_pay[k].inst_type;
      w_pkt[k].preg      = r_pay[k].preg;
      w_pkt[k].check     = r_pay[k].check;
      w_pkt[k].imm       = r_pay[k].imm;
      for (int s = 0; s < 2; s++) begin
        w_pkt[k].src_rdy[s]   = w_src_rdy[2*k+s];
        w_pkt[k].src_robid[s] = w_src_robid[2*k+s];
        w_pkt[k].src_data[s]  = w_src_data[2*k+s];
      end
    end
  end

  assign w_alu0 = w_off0 & (r_tgt[0] == IQ_ALU);
  assign w_alu1 = w_off1 & (r_tgt[1] == IQ_ALU);
  assign w_lsu0 = w_off0 & (r_tgt[0] == IQ_LSU);
  assign w_lsu1 = w_off1 & (r_tgt[1] == IQ_LSU);

  assign alu_valid_o = w_alu0 | w_alu1;
  assign lsu_valid_o = w_lsu0 | w_lsu1;
  assign alu_data_o  = w_alu0 ? w_pkt[0] : (w_alu1 ? w_pkt[1] : '0);
  assign lsu_data_o  = w_lsu0 ? w_pkt[0] : (w_lsu1 ? w_pkt[1] : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_cap && |w_rv) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (c_flush_i)   w_state_nxt = ST_EMPTY;
        else if (w_cap)  w_state_nxt = |w_rv ? ST_HOLD : ST_EMPTY;
        else if (w_drain) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_pend_nxt = r_pend & ~{w_disp1, w_disp0};
    if (c_flush_i)  w_pend_nxt = '0;
    else if (w_cap) w_pend_nxt = w_rv;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_pend  <= '0;
      for (int k = 0; k < 2; k++) begin
        r_tgt[k] <= IQ_ALU;
        r_pay[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_cap) begin
        for (int k = 0; k < 2; k++) begin
          r_tgt[k]           <= inst_target(r_p_data_i.slot[k].inst_type);
          r_pay[k].inst_type <= r_p_data_i.slot[k].inst_type;
          r_pay[k].preg      <= r_p_data_i.slot[k].preg;
          r_pay[k].check     <= r_p_data_i.slot[k].check;
          r_pay[k].imm       <= r_p_data_i.slot[k].imm;
        end
      end
    end
  end

endmodule
